// File: rtl/short_preamble_autocorr_pkg.sv
// Shared helpers for the preamble-sync chain: default lag/window lengths,
// the sum-width rule and the max+min/2 magnitude approximation.
package short_preamble_autocorr_pkg;

    localparam int DEF_LAG   = 16;
    localparam int DEF_WIN   = 16;
    localparam int MAG_MAX_W = 64;

    typedef logic [MAG_MAX_W-1:0] mag_t;

    // A WIN-deep sum of prod_w-bit terms cannot exceed prod_w + log2(WIN) bits.
    function automatic int sum_width(input int prod_w, input int win);
        return prod_w + $clog2(win);
    endfunction

    function automatic mag_t mag_approx(input mag_t abs_a, input mag_t abs_b);
        mag_t hi_v;
        mag_t lo_v;
        if (abs_a >= abs_b) begin
            hi_v = abs_a;
            lo_v = abs_b;
        end else begin
            hi_v = abs_b;
            lo_v = abs_a;
        end
        return hi_v + (lo_v >> 1);
    endfunction

endpackage

// File: rtl/short_preamble_autocorr_moving_sum.sv
// Strobe-driven moving sum over the last WIN input terms, signed, with a
// synchronous clear of both the term history and the running total.
module moving_sum
    import short_preamble_autocorr_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int WIN   = DEF_WIN
) (
    input  logic                               CLK,
    input  logic                               clear,
    input  logic                               strobe,
    input  logic [WIDTH-1:0]                   in,
    output logic [sum_width(WIDTH, WIN)-1:0]   sum
);

    localparam int SUM_W = sum_width(WIDTH, WIN);

    logic [WIDTH-1:0] dl_reg [WIN];
    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] in_ext;
    logic [SUM_W-1:0] old_ext;

    always_comb begin
        in_ext  = {{(SUM_W-WIDTH){in[WIDTH-1]}}, in};
        old_ext = {{(SUM_W-WIDTH){dl_reg[WIN-1][WIDTH-1]}}, dl_reg[WIN-1]};
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            sum_reg <= '0;
            for (int k = 0; k < WIN; k++) dl_reg[k] <= '0;
        end else if (strobe) begin
            sum_reg   <= sum_reg + in_ext - old_ext;
            dl_reg[0] <= in;
            for (int k = 1; k < WIN; k++) dl_reg[k] <= dl_reg[k-1];
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/short_preamble_autocorr.sv
// Lag-LAG delayed autocorrelation plateau detector: a fixed 4-cycle pipeline
// producing one strobe and detect flag per accepted input sample.
module short_preamble_autocorr
    import short_preamble_autocorr_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LAG       = DEF_LAG,
    parameter int WIN       = DEF_WIN,
    parameter int THRESH_Q4 = 12,
    parameter int POWER_MIN = 64
) (
    input  logic                               CLK,
    input  logic                               s_RST,
    input  logic                               enable,
    input  logic                               In_Strobe,
    input  logic [DATA_W-1:0]                  In_I,
    input  logic [DATA_W-1:0]                  In_Q,
    output logic                               Out_Strobe,
    output logic                               Out_Det,
    output logic [2*DATA_W+$clog2(WIN):0]      Out_Corr_Mag,
    output logic [2*DATA_W+$clog2(WIN):0]      Out_Power
);

    localparam int PROD_W = 2*DATA_W + 1;
    localparam int SUM_W  = sum_width(PROD_W, WIN);
    localparam int OUT_W  = 2*DATA_W + $clog2(WIN) + 1;
    localparam int CMP_W  = SUM_W + 5;
    localparam int WARM_N = LAG + WIN;
    localparam int CNT_W  = $clog2(WARM_N + 1);

    logic clear;
    assign clear = s_RST || !enable;

    // Stage 0: capture sample and its lagged partner, advance delay line.
    logic [DATA_W-1:0]        dl_i_reg [LAG];
    logic [DATA_W-1:0]        dl_q_reg [LAG];
    logic signed [DATA_W-1:0] x_i_reg, x_q_reg, lag_i_reg, lag_q_reg;
    logic [CNT_W-1:0]         warm_cnt_reg;
    logic                     v0_reg, warm0_reg;

    always_ff @(posedge CLK) begin
        if (clear) begin
            for (int k = 0; k < LAG; k++) begin
                dl_i_reg[k] <= '0;
                dl_q_reg[k] <= '0;
            end
            x_i_reg      <= '0;
            x_q_reg      <= '0;
            lag_i_reg    <= '0;
            lag_q_reg    <= '0;
            warm_cnt_reg <= '0;
            v0_reg       <= 1'b0;
            warm0_reg    <= 1'b0;
        end else begin
            v0_reg <= In_Strobe;
            if (In_Strobe) begin
                x_i_reg     <= In_I;
                x_q_reg     <= In_Q;
                lag_i_reg   <= dl_i_reg[LAG-1];
                lag_q_reg   <= dl_q_reg[LAG-1];
                dl_i_reg[0] <= In_I;
                dl_q_reg[0] <= In_Q;
                for (int k = 1; k < LAG; k++) begin
                    dl_i_reg[k] <= dl_i_reg[k-1];
                    dl_q_reg[k] <= dl_q_reg[k-1];
                end
                warm0_reg <= (warm_cnt_reg >= CNT_W'(WARM_N));
                if (warm_cnt_reg < CNT_W'(WARM_N))
                    warm_cnt_reg <= warm_cnt_reg + 1'b1;
            end
        end
    end

    // Stage 1: x[n]*conj(x[n-LAG]) and |x[n]|^2 at full precision.
    logic signed [2*DATA_W-1:0] m_ii, m_qq, m_qi, m_iq, s_ii, s_qq;
    logic [PROD_W-1:0]          prod_next [3];
    logic [PROD_W-1:0]          prod_reg  [3];
    logic                       v1_reg, warm1_reg;

    always_comb begin
        m_ii = x_i_reg * lag_i_reg;
        m_qq = x_q_reg * lag_q_reg;
        m_qi = x_q_reg * lag_i_reg;
        m_iq = x_i_reg * lag_q_reg;
        s_ii = x_i_reg * x_i_reg;
        s_qq = x_q_reg * x_q_reg;
        prod_next[0] = {m_ii[2*DATA_W-1], m_ii} + {m_qq[2*DATA_W-1], m_qq};
        prod_next[1] = {m_qi[2*DATA_W-1], m_qi} - {m_iq[2*DATA_W-1], m_iq};
        prod_next[2] = {s_ii[2*DATA_W-1], s_ii} + {s_qq[2*DATA_W-1], s_qq};
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            for (int k = 0; k < 3; k++) prod_reg[k] <= '0;
            v1_reg    <= 1'b0;
            warm1_reg <= 1'b0;
        end else begin
            v1_reg <= v0_reg;
            if (v0_reg) begin
                for (int k = 0; k < 3; k++) prod_reg[k] <= prod_next[k];
                warm1_reg <= warm0_reg;
            end
        end
    end

    // Stage 2: running sums for corr re, corr im and power.
    logic [SUM_W-1:0] sum_w [3];
    logic             v2_reg, warm2_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sum
            moving_sum #(
                .WIDTH (PROD_W),
                .WIN   (WIN)
            ) u_moving_sum (
                .CLK    (CLK),
                .clear  (clear),
                .strobe (v1_reg),
                .in     (prod_reg[gi]),
                .sum    (sum_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (clear) begin
            v2_reg    <= 1'b0;
            warm2_reg <= 1'b0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) warm2_reg <= warm1_reg;
        end
    end

    // Stage 3: magnitude approximation and scaled power.
    logic [SUM_W:0]   re_ext, im_ext, abs_re, abs_im, mag_next;
    logic [CMP_W-1:0] pow_scaled_next;
    mag_t             mag_full;
    logic             unused_mag_hi;

    always_comb begin
        re_ext          = {sum_w[0][SUM_W-1], sum_w[0]};
        im_ext          = {sum_w[1][SUM_W-1], sum_w[1]};
        abs_re          = re_ext[SUM_W] ? ('0 - re_ext) : re_ext;
        abs_im          = im_ext[SUM_W] ? ('0 - im_ext) : im_ext;
        mag_full        = mag_approx(mag_t'(abs_re), mag_t'(abs_im));
        mag_next        = mag_full[SUM_W:0];
        pow_scaled_next = CMP_W'(sum_w[2]) * CMP_W'(THRESH_Q4);
    end

    assign unused_mag_hi = ^mag_full[MAG_MAX_W-1:SUM_W+1];

    logic [SUM_W:0]   mag_reg;
    logic [SUM_W-1:0] pow_reg;
    logic [CMP_W-1:0] pow_scaled_reg;
    logic             v3_reg, warm3_reg;

    always_ff @(posedge CLK) begin
        if (clear) begin
            mag_reg        <= '0;
            pow_reg        <= '0;
            pow_scaled_reg <= '0;
            v3_reg         <= 1'b0;
            warm3_reg      <= 1'b0;
        end else begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                mag_reg        <= mag_next;
                pow_reg        <= sum_w[2];
                pow_scaled_reg <= pow_scaled_next;
                warm3_reg      <= warm2_reg;
            end
        end
    end

    // Stage 4: strict plateau compare, mag*16 > power*THRESH_Q4.
    always_ff @(posedge CLK) begin
        if (clear) begin
            Out_Strobe   <= 1'b0;
            Out_Det      <= 1'b0;
            Out_Corr_Mag <= '0;
            Out_Power    <= '0;
        end else begin
            Out_Strobe <= v3_reg;
            Out_Det    <= v3_reg && warm3_reg
                          && (pow_reg >= SUM_W'(POWER_MIN))
                          && ({mag_reg, 4'b0000} > pow_scaled_reg);
            if (v3_reg) begin
                Out_Corr_Mag <= mag_reg[OUT_W-1:0];
                Out_Power    <= pow_reg[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_short_preamble_autocorr.sv
// Directed bench for short_preamble_autocorr: a window-sum reference model
// predicts every output cycle, plus hand-counted plateau/warm-up figures.
module tb_short_preamble_autocorr;

    localparam int OUT_W = 37;
    localparam int LAG   = 16;
    localparam int WIN   = 16;

    logic             CLK;
    logic             s_RST;
    logic             enable;
    logic             In_Strobe;
    logic [15:0]      In_I;
    logic [15:0]      In_Q;
    logic             Out_Strobe;
    logic             Out_Det;
    logic [OUT_W-1:0] Out_Corr_Mag;
    logic [OUT_W-1:0] Out_Power;

    short_preamble_autocorr dut (
        .CLK          (CLK),
        .s_RST        (s_RST),
        .enable       (enable),
        .In_Strobe    (In_Strobe),
        .In_I         (In_I),
        .In_Q         (In_Q),
        .Out_Strobe   (Out_Strobe),
        .Out_Det      (Out_Det),
        .Out_Corr_Mag (Out_Corr_Mag),
        .Out_Power    (Out_Power)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int               due;
        logic             det;
        logic [OUT_W-1:0] mag;
        logic [OUT_W-1:0] pow;
    } exp_t;

    exp_t             exp_q[$];
    int               hist_i[$];
    int               hist_q[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [OUT_W-1:0] hold_mag = '0;
    logic [OUT_W-1:0] hold_pow = '0;
    int               obs_strobes = 0;
    int               obs_dets = 0;
    int               first_det = 0;

    int per_i[16] = '{8000, 7391, 5657, 3061, 0, -3061, -5657, -7391,
                      -8000, -7391, -5657, -3061, 0, 3061, 5657, 7391};

    // Reference: direct sums over the window, zeros before the first sample.
    task automatic accept_sample(input int si, input int sq);
        longint re, im, pw, ar, ai, mag;
        int     n;
        exp_t   e;
        hist_i.push_back(si);
        hist_q.push_back(sq);
        n  = hist_i.size() - 1;
        re = 0; im = 0; pw = 0;
        for (int j = n - WIN + 1; j <= n; j++) begin
            longint a, b, c, d;
            if (j < 0) continue;
            a = hist_i[j];
            b = hist_q[j];
            c = (j >= LAG) ? longint'(hist_i[j-LAG]) : 0;
            d = (j >= LAG) ? longint'(hist_q[j-LAG]) : 0;
            re += a*c + b*d;
            im += b*c - a*d;
            pw += a*a + b*b;
        end
        ar  = (re < 0) ? -re : re;
        ai  = (im < 0) ? -im : im;
        mag = (ar >= ai) ? ar + ai/2 : ai + ar/2;
        e.due = cyc + 4;
        e.det = (mag*16 > pw*12) && (pw >= 64) && (n >= LAG + WIN);
        e.mag = mag[OUT_W-1:0];
        e.pow = pw[OUT_W-1:0];
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input logic en, input logic rst, input logic stb,
                               input int si, input int sq);
        logic exp_stb, exp_det;
        enable    = en;
        s_RST     = rst;
        In_Strobe = stb;
        In_I      = si[15:0];
        In_Q      = sq[15:0];
        @(posedge CLK);
        cyc++;
        if (rst || !en) begin
            exp_q.delete();
            hist_i.delete();
            hist_q.delete();
            hold_mag    = '0;
            hold_pow    = '0;
            obs_strobes = 0;
            obs_dets    = 0;
            first_det   = 0;
        end else if (stb) begin
            accept_sample(si, sq);
        end
        #1;
        exp_stb = 1'b0;
        exp_det = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_stb  = 1'b1;
            exp_det  = exp_q[0].det;
            hold_mag = exp_q[0].mag;
            hold_pow = exp_q[0].pow;
            void'(exp_q.pop_front());
        end
        n_cmp += 4;
        if (Out_Strobe !== exp_stb) begin
            n_bad++;
            $display("FAIL out_strobe cyc=%0d got=%b want=%b", cyc, Out_Strobe, exp_stb);
        end
        if (Out_Det !== exp_det) begin
            n_bad++;
            $display("FAIL out_det cyc=%0d got=%b want=%b", cyc, Out_Det, exp_det);
        end
        if (Out_Corr_Mag !== hold_mag) begin
            n_bad++;
            $display("FAIL corr_mag cyc=%0d got=%0d want=%0d", cyc, Out_Corr_Mag, hold_mag);
        end
        if (Out_Power !== hold_pow) begin
            n_bad++;
            $display("FAIL power cyc=%0d got=%0d want=%0d", cyc, Out_Power, hold_pow);
        end
        if (Out_Strobe === 1'b1) begin
            obs_strobes++;
            if (Out_Det === 1'b1) begin
                obs_dets++;
                if (first_det == 0) first_det = obs_strobes;
            end
            $display("cyc %0d strobe %0d det=%b mag=%0d pow=%0d",
                     cyc, obs_strobes, Out_Det, Out_Corr_Mag, Out_Power);
        end
    endtask

    // mode: 0 periodic table, 1 full-scale alternating, 2 zeros, 3 random
    task automatic run_stream(input int n_samp, input int gap, input int mode,
                              input int drop_at, input int rst_at);
        int si, sq;
        for (int s = 0; s < n_samp; s++) begin
            case (mode)
                0:       begin si = per_i[s % 16]; sq = per_i[(s + 12) % 16]; end
                1:       begin si = (s % 2 == 0) ? -32768 : 32767; sq = (s % 2 == 0) ? 32767 : -32768; end
                2:       begin si = 0; sq = 0; end
                default: begin si = int'($urandom_range(16000)) - 8000; sq = int'($urandom_range(16000)) - 8000; end
            endcase
            if (s == drop_at) drive_cycle(1'b0, 1'b0, 1'b1, si, sq);
            if (s == rst_at)  drive_cycle(1'b1, 1'b1, 1'b1, si, sq);
            drive_cycle(1'b1, 1'b0, 1'b1, si, sq);
            for (int g = 0; g < gap; g++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
        end
        for (int g = 0; g < 6; g++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, 1'b1, 1234, -4321);
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (obs_strobes !== 0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%0d want=0", obs_strobes);
        end
    endtask

    task automatic test_periodic();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(160, 0, 0, -1, -1);
        n_cmp += 3;
        if (obs_strobes !== 160) begin n_bad++; $display("FAIL periodic_strobes got=%0d want=160", obs_strobes); end
        if (first_det !== 33)    begin n_bad++; $display("FAIL periodic_first_det got=%0d want=33", first_det); end
        if (obs_dets !== 128)    begin n_bad++; $display("FAIL periodic_dets got=%0d want=128", obs_dets); end
    endtask

    task automatic test_uncorrelated();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(256, 0, 3, -1, -1);
        n_cmp++;
        if (obs_strobes !== 256) begin n_bad++; $display("FAIL random_strobes got=%0d want=256", obs_strobes); end
    endtask

    task automatic test_zero();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(100, 0, 2, -1, -1);
        n_cmp += 4;
        if (obs_strobes !== 100)  begin n_bad++; $display("FAIL zero_strobes got=%0d want=100", obs_strobes); end
        if (obs_dets !== 0)       begin n_bad++; $display("FAIL zero_dets got=%0d want=0", obs_dets); end
        if (Out_Corr_Mag !== '0)  begin n_bad++; $display("FAIL zero_mag got=%0d want=0", Out_Corr_Mag); end
        if (Out_Power !== '0)     begin n_bad++; $display("FAIL zero_power got=%0d want=0", Out_Power); end
    endtask

    task automatic test_full_scale();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(64, 0, 1, -1, -1);
        n_cmp += 4;
        if (first_det !== 33) begin n_bad++; $display("FAIL full_first_det got=%0d want=33", first_det); end
        if (obs_dets !== 32)  begin n_bad++; $display("FAIL full_dets got=%0d want=32", obs_dets); end
        if (Out_Power !== 37'd34358689808)
            begin n_bad++; $display("FAIL full_power got=%0d want=34358689808", Out_Power); end
        if (Out_Corr_Mag !== 37'd34358689808)
            begin n_bad++; $display("FAIL full_mag got=%0d want=34358689808", Out_Corr_Mag); end
    endtask

    task automatic test_gapped();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(160, 2, 0, -1, -1);
        n_cmp += 3;
        if (obs_strobes !== 160) begin n_bad++; $display("FAIL gapped_strobes got=%0d want=160", obs_strobes); end
        if (first_det !== 33)    begin n_bad++; $display("FAIL gapped_first_det got=%0d want=33", first_det); end
        if (obs_dets !== 128)    begin n_bad++; $display("FAIL gapped_dets got=%0d want=128", obs_dets); end
    endtask

    task automatic test_enable_drop();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(160, 0, 0, 80, -1);
        n_cmp += 3;
        if (obs_strobes !== 80) begin n_bad++; $display("FAIL drop_strobes got=%0d want=80", obs_strobes); end
        if (first_det !== 33)   begin n_bad++; $display("FAIL drop_first_det got=%0d want=33", first_det); end
        if (obs_dets !== 48)    begin n_bad++; $display("FAIL drop_dets got=%0d want=48", obs_dets); end
    endtask

    task automatic test_reset_pulse();
        drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run_stream(160, 0, 0, -1, 90);
        n_cmp += 3;
        if (obs_strobes !== 70) begin n_bad++; $display("FAIL rst_strobes got=%0d want=70", obs_strobes); end
        if (first_det !== 33)   begin n_bad++; $display("FAIL rst_first_det got=%0d want=33", first_det); end
        if (obs_dets !== 38)    begin n_bad++; $display("FAIL rst_dets got=%0d want=38", obs_dets); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_uncorrelated();
        test_zero();
        test_full_scale();
        test_gapped();
        test_enable_drop();
        test_reset_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/short_preamble_autocorr.md
Name: short_preamble_autocorr

Overview:
- Upstream stage of the short-preamble detect counter in the synchronisation chain.
- Per input sample it computes the lag-16 delayed autocorrelation and the window power over the last WIN samples, then decides whether the sample lies on a short-preamble plateau.
- Emits one output strobe per input sample, plus a per-sample detect flag. The downstream counter then counts consecutive detects.

Parameters:
- DATA_W, 16, signed I/Q sample width.
- LAG, 16, autocorrelation lag in samples (short-symbol period).
- WIN, 16, moving-sum window length. Must be a power of 2.
- THRESH_Q4, 12, plateau threshold in Q4 (12/16 = 0.75).
- POWER_MIN, 64, minimum window power for a valid detect (noise gate).

Ports:
- CLK  in  1  clock
- s_RST  in  1  synchronous active-high reset
- enable  in  1  low = clear all state
- In_Strobe  in  1  input sample valid, 1-cycle qualifier
- In_I  in  DATA_W  signed in-phase sample
- In_Q  in  DATA_W  signed quadrature sample
- Out_Strobe  out  1  registered; one pulse per accepted input sample
- Out_Det  out  1  registered; plateau decision for that sample, meaningful only while Out_Strobe=1
- Out_Corr_Mag  out  2*DATA_W+log2(WIN)+1  registered correlation magnitude, debug/monitor
- Out_Power  out  same width  registered window power, debug/monitor

Behaviour:
- Reset: s_RST=1 at a CLK edge clears all outputs to 0. It also clears the sample delay line, the product delay lines, the running sums, the warm-up counter and the pipeline valid bits.
- enable=0: same clearing as reset, applied on the same edge. While enable=0, In_Strobe is ignored.
- Sample delay line (LAG deep) advances only on accepted strobes. Gaps between strobes are allowed; results depend on sample order only, not timing.
- Pipeline: fixed 4 cycles. A strobe accepted at edge k gives Out_Strobe=1 for exactly the cycle after edge k+4. Back-to-back strobes (one per cycle) give back-to-back outputs.
- S1 computes three full-precision products:
  - p_corr = x[n]*conj(x[n-LAG]), complex, re and im each 2*DATA_W+1 bits.
  - p_pow = |x[n]|^2, unsigned.
- S2 updates running sums: sum += new product - product from WIN strobes earlier (WIN-deep product delay lines). Sum width = product width + log2(WIN); no saturation, and overflow is impossible by construction.
- S3 computes:
  - mag = max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - Absolute values are taken at width+1 so -2^(N-1) does not overflow.
  - powscaled = power*THRESH_Q4.
- S4 compares:
  - Out_Det = (mag*16 > powscaled) AND (power >= POWER_MIN) AND warm.
  - The comparison is strict, done in unsigned full width.
  - Out_Corr_Mag and Out_Power update with the strobe; otherwise they hold.
- Warm-up:
  - A saturating counter increments per accepted strobe; warm = count >= LAG+WIN.
  - Out_Det is forced 0 on the first LAG+WIN output strobes.
  - Counter width is ceil(log2(LAG+WIN+1)).
- Out_Det is registered with Out_Strobe and changes only on strobe cycles. When Out_Strobe=0, Out_Det=0.
- enable falling mid-pipeline: in-flight samples are discarded, with no Out_Strobe for them. Warm-up restarts when enable returns.
- In_Strobe asserted in the same cycle enable rises: the sample is accepted.

Decomposition:
- Shared sync package holds:
  - the width function for sum/mag,
  - the magnitude-approximation function,
  - default LAG/WIN constants, reused by the long-preamble stage.
- One natural sub-module: moving_sum (parameters WIDTH, WIN). Ports: strobe, in, clear, sum. Instantiated 3× for corr_re, corr_im and power.

Test Plan:
- Periodic input: repeat one 16-sample complex sequence, amplitude ~8000, In_Strobe every cycle for 160 samples.
  -> Out_Det=0 for output strobes 1..32, then 1 for every later strobe. Out_Strobe lags In_Strobe by exactly 4 cycles.
- Uncorrelated input: 256 random samples, amplitude ~8000.
  -> Out_Det=0 on all strobes after warm-up. Out_Power ≈ 16×E|x|^2 matches the model exactly.
- All-zero input for 100 strobes.
  -> power=0 < POWER_MIN, so Out_Det=0 throughout, and Out_Corr_Mag=0.
- Periodic input at full scale (-32768/32767 alternating pattern).
  -> Sums match a bit-exact model with no wrap. Out_Det=1 after warm-up.
- Periodic input with In_Strobe every 3rd cycle.
  -> Out_Det/Out_Corr_Mag sequence is identical to the continuous case. Each Out_Strobe comes 4 cycles after its In_Strobe.
- enable dropped for 1 cycle at sample 80 of the periodic run, and separately s_RST pulsed at sample 90.
  -> All outputs are 0 on the next cycle and no strobes emerge for in-flight samples. After re-enable, Out_Det stays 0 for 32 output strobes, then returns to 1.
